// File: rtl/mux_nto1_pipe.sv
// Pipelined N-to-1 multiplexer: a binary tree of registered 2:1 ranks, with valid
// and channel tag carried alongside the data. Select is direct (Sel) or auto-scan.
module mux_nto1_pipe #(
   parameter int WIDTH = 8,
   parameter int NCH   = 7,
   parameter int SELW  = 3
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [NCH*WIDTH-1:0]  In,
   input  logic [SELW-1:0]       Sel,
   input  logic                  Mode,
   input  logic                  InValid,
   output logic [WIDTH-1:0]      Z,
   output logic                  ZValid,
   output logic [SELW-1:0]       ZTag,
   output logic [SELW-1:0]       ScanPtr
);

   localparam int NLEAF = 1 << SELW;
   localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

   // Heap numbering: node n has children 2n and 2n+1; leaves sit at NLEAF..2*NLEAF-1.
   logic [WIDTH-1:0] leaf     [NLEAF];
   logic [WIDTH-1:0] full     [2:2*NLEAF-1];
   logic [WIDTH-1:0] node     [1:NLEAF-1];
   logic [WIDTH-1:0] node_nxt [1:NLEAF-1];
   logic [SELW-1:0]  sel_q    [SELW];
   logic [SELW-1:0]  s_in     [SELW];
   logic             v_q      [SELW];
   logic             v_in     [SELW];
   logic [SELW-1:0]  eff_sel;
   logic [SELW-1:0]  clamp_sel;

   // The clamped select doubles as the tag, so ZTag never shows an out-of-range value.
   always_comb begin
      eff_sel   = Mode ? ScanPtr : Sel;
      clamp_sel = (eff_sel > LAST) ? LAST : eff_sel;
   end

   always_comb begin
      for (int k = 0; k < NLEAF; k++) begin
         leaf[k] = In[((k < NCH) ? k : NCH - 1) * WIDTH +: WIDTH];
      end
   end

   always_comb begin
      for (int n = 2; n < NLEAF; n++) begin
         full[n] = node[n];
      end
      for (int n = NLEAF; n < 2 * NLEAF; n++) begin
         full[n] = leaf[n - NLEAF];
      end
   end

   always_comb begin
      s_in[0] = clamp_sel;
      v_in[0] = InValid;
      for (int i = 1; i < SELW; i++) begin
         s_in[i] = sel_q[i-1];
         v_in[i] = v_q[i-1];
      end
   end

   // Level i covers nodes NLEAF>>(i+1) .. (NLEAF>>i)-1 and is steered by bit i of its own sample.
   always_comb begin
      for (int n = 1; n < NLEAF; n++) begin
         node_nxt[n] = '0;
      end
      for (int i = 0; i < SELW; i++) begin
         for (int n = NLEAF >> (i + 1); n < (NLEAF >> i); n++) begin
            node_nxt[n] = s_in[i][i] ? full[2*n+1] : full[2*n];
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int n = 1; n < NLEAF; n++) begin
            node[n] <= '0;
         end
         for (int i = 0; i < SELW; i++) begin
            v_q[i]   <= 1'b0;
            sel_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SELW; i++) begin
            v_q[i] <= v_in[i];
            if (v_in[i]) begin
               sel_q[i] <= s_in[i];
               for (int n = NLEAF >> (i + 1); n < (NLEAF >> i); n++) begin
                  node[n] <= node_nxt[n];
               end
            end
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ScanPtr <= '0;
      end else if (!Mode) begin
         ScanPtr <= '0;
      end else if (InValid) begin
         ScanPtr <= (ScanPtr == LAST) ? '0 : ScanPtr + 1'b1;
      end
   end

   assign Z      = node[1];
   assign ZValid = v_q[SELW-1];
   assign ZTag   = sel_q[SELW-1];

endmodule
